// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: PC/BD/exception/valid/payload bundle with
// stall-hold, bubble insertion, exception flush and saturating event counters.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W     = 64,
  parameter int unsigned        PC_W       = 32,
  parameter int unsigned        EXC_W      = 5,
  parameter logic [PC_W-1:0]    RESET_PC   = 32'h0000_3000,
  parameter logic [PC_W-1:0]    HANDLER_PC = 32'h0000_4180,
  parameter int unsigned        CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              bubble,
  input  logic              exc_flush,
  input  logic              valid_in,
  input  logic [PC_W-1:0]   PC_in,
  input  logic              BD_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [PC_W-1:0]   PC_out,
  output logic              BD_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  inst_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      PC_out    <= RESET_PC;
      BD_out    <= 1'b0;
      exc_out   <= '0;
      data_out  <= '0;
    end else if (exc_flush) begin
      valid_out <= 1'b0;
      PC_out    <= HANDLER_PC;
      BD_out    <= 1'b0;
      exc_out   <= '0;
      data_out  <= '0;
    end else if (!stall) begin
      // A bubble still tracks PC/BD so CP0 sees a sensible EPC for the slot.
      PC_out <= PC_in;
      BD_out <= BD_in;
      if (bubble) begin
        valid_out <= 1'b0;
        exc_out   <= '0;
        data_out  <= '0;
      end else begin
        valid_out <= valid_in;
        exc_out   <= exc_in;
        data_out  <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      inst_cnt   <= '0;
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (exc_flush) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else if (bubble) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end else if (valid_in) begin
      inst_cnt <= sat_inc(inst_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (narrow counters to reach saturation).
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned EXC_W  = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset, stall, bubble, exc_flush, valid_in, BD_in, cnt_clr;
  logic [PC_W-1:0]   PC_in;
  logic [EXC_W-1:0]  exc_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_out, BD_out;
  logic [PC_W-1:0]   PC_out;
  logic [EXC_W-1:0]  exc_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  inst_cnt, bubble_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W),
    .RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble), .exc_flush(exc_flush),
    .valid_in(valid_in), .PC_in(PC_in), .BD_in(BD_in), .exc_in(exc_in), .data_in(data_in),
    .valid_out(valid_out), .PC_out(PC_out), .BD_out(BD_out), .exc_out(exc_out),
    .data_out(data_out), .cnt_clr(cnt_clr), .inst_cnt(inst_cnt),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; bubble = 1'b0; exc_flush = 1'b0; cnt_clr = 1'b0;
    valid_in = 1'b0; PC_in = '0; BD_in = 1'b0; exc_in = '0; data_in = '0;
    step();
    chk("rst_pc", PC_out, 64'h3000);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_inst", inst_cnt, 0);
    chk("rst_bub", bubble_cnt, 0);
    chk("rst_stall", stall_cnt, 0);

    reset = 1'b0; valid_in = 1'b1; PC_in = 32'h3004; BD_in = 1'b1; data_in = 64'h11;
    step();
    chk("ld_pc", PC_out, 64'h3004);
    chk("ld_bd", BD_out, 1);
    chk("ld_valid", valid_out, 1);
    chk("ld_inst", inst_cnt, 1);

    PC_in = 32'h3008; BD_in = 1'b0; data_in = 64'hDEAD_BEEF; exc_in = 5'd0;
    step();
    chk("ld2_data", data_out, 64'hDEAD_BEEF);
    chk("ld2_inst", inst_cnt, 2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_in = i[0]; PC_in = 32'h5000 + 32'(i); BD_in = 1'b1;
      exc_in = 5'd7; data_in = 64'h1234_0000 + 64'(i);
      step();
      chk("stall_data", data_out, 64'hDEAD_BEEF);
      chk("stall_pc", PC_out, 64'h3008);
      chk("stall_bd", BD_out, 0);
      chk("stall_exc", exc_out, 0);
      chk("stall_valid", valid_out, 1);
    end
    chk("stall_cnt3", stall_cnt, 3);
    chk("stall_inst", inst_cnt, 2);

    stall = 1'b0; bubble = 1'b1; valid_in = 1'b1;
    PC_in = 32'h3010; BD_in = 1'b1; exc_in = 5'd4; data_in = 64'h123;
    step();
    chk("bub_valid", valid_out, 0);
    chk("bub_exc", exc_out, 0);
    chk("bub_data", data_out, 0);
    chk("bub_pc", PC_out, 64'h3010);
    chk("bub_bd", BD_out, 1);
    chk("bub_cnt", bubble_cnt, 1);
    chk("bub_inst", inst_cnt, 2);

    stall = 1'b1; PC_in = 32'h3014;
    step();
    chk("stbub_stall", stall_cnt, 4);
    chk("stbub_bub", bubble_cnt, 1);
    chk("stbub_pc", PC_out, 64'h3010);

    exc_flush = 1'b1; bubble = 1'b0;
    step();
    chk("fl_pc", PC_out, 64'h4180);
    chk("fl_valid", valid_out, 0);
    chk("fl_bd", BD_out, 0);
    chk("fl_bub", bubble_cnt, 2);
    chk("fl_stall", stall_cnt, 4);

    exc_flush = 1'b0; stall = 1'b0; valid_in = 1'b1;
    PC_in = 32'h3020; BD_in = 1'b0; exc_in = 5'd3; data_in = 64'h55;
    step();
    chk("exc_out", exc_out, 3);
    chk("exc_inst", inst_cnt, 3);

    exc_in = 5'd0;
    for (int i = 0; i < 20; i++) begin
      PC_in = 32'h3100 + 32'(i * 4);
      step();
    end
    chk("sat_inst", inst_cnt, 15);
    chk("sat_pc", PC_out, 64'h314C);

    cnt_clr = 1'b1; PC_in = 32'h3200; data_in = 64'h77;
    step();
    chk("clr_inst", inst_cnt, 0);
    chk("clr_bub", bubble_cnt, 0);
    chk("clr_stall", stall_cnt, 0);
    chk("clr_pc", PC_out, 64'h3200);
    chk("clr_data", data_out, 64'h77);

    cnt_clr = 1'b0; PC_in = 32'h3040; data_in = 64'hAA;
    step();
    chk("pre_inst", inst_cnt, 1);
    stall = 1'b1;
    step();
    chk("pre_stall", stall_cnt, 1);
    reset = 1'b1;
    step();
    chk("rs_pc", PC_out, 64'h3000);
    chk("rs_valid", valid_out, 0);
    chk("rs_data", data_out, 0);
    chk("rs_inst", inst_cnt, 0);
    chk("rs_stall", stall_cnt, 0);
    chk("rs_bub", bubble_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS32 core. It replaces the per-stage single-field PC registers with one bundle that carries PC, the branch-delay flag, the exception code, a valid bit and an opaque data payload. It supports stall-hold, bubble insertion and exception flush, and it includes saturating per-stage event counters. One instance sits at each stage boundary (F/D, D/E, E/M, M/W); the M/W instance feeds CP0 and the register-file writeback.

## Interface
Parameters:
- DATA_W, 64: width of the opaque payload (control bits, operands, results).
- PC_W, 32: PC width.
- EXC_W, 5: exception-code width (CP0 ExcCode).
- RESET_PC, 32'h0000_3000: PC_out value after reset.
- HANDLER_PC, 32'h0000_4180: PC_out value after exception flush.
- CNT_W, 16: event-counter width.

Ports:
- clk, in, 1: clock; every register updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- stall, in, 1: hold the current contents.
- bubble, in, 1: load a bubble in place of the incoming instruction.
- exc_flush, in, 1: exception or eret taken; kill the contents.
- valid_in, in, 1: the incoming instruction is real.
- PC_in, in, PC_W: incoming PC.
- BD_in, in, 1: the incoming instruction is in a delay slot.
- exc_in, in, EXC_W: pending exception code; 0 means none.
- data_in, in, DATA_W: payload.
- valid_out, PC_out, BD_out, exc_out, data_out, out, same widths as the inputs: registered copies.
- cnt_clr, in, 1: synchronous clear of all counters.
- inst_cnt, out, CNT_W: count of valid instructions loaded.
- bubble_cnt, out, CNT_W: count of bubble and flush insertions.
- stall_cnt, out, CNT_W: count of stalled cycles.

## Operation
The register has no FSM. Each cycle exactly one action applies, chosen by strict priority: reset > exc_flush > stall > bubble > load.
- reset: valid_out=0, PC_out=RESET_PC, BD_out=0, exc_out=0, data_out=0. All counters are set to 0.
- exc_flush: valid_out=0, PC_out=HANDLER_PC, BD_out=0, exc_out=0, data_out=0. bubble_cnt increments.
- stall: all output registers hold their value. stall_cnt increments.
- bubble: valid_out=0, exc_out=0, data_out=0. PC_out=PC_in and BD_out=BD_in are still captured, so CP0 sees a correct macroscopic PC/EPC for the bubble. bubble_cnt increments.
- load: all outputs take their inputs. inst_cnt increments if and only if valid_in=1.
- valid_in=0 on a load copies the payload as given. Upstream is responsible for zeroing the payload of an invalid instruction.
- Counters saturate at all-ones; they never wrap.
- cnt_clr zeroes the counters on that edge and overrides any increment in the same cycle. cnt_clr does not affect the data path.
- Reset overrides cnt_clr.
- Counter updates follow the same priority as the data path. In particular, stall together with bubble increments stall_cnt only.

## Timing
- Latency: one cycle from input to output. There is no combinational path from any input to any output.
- Outputs take their reset values on the first rising edge with reset=1. They are undefined before that edge.
- Reset asserted mid-stall or mid-flush wins on that same edge.
- exc_flush asserted together with stall: the flush wins, so a stalled instruction is killed and not held.
- Stall held for N cycles: outputs remain constant for N edges. stall_cnt advances by N (saturating).
- Deasserting stall: the next edge performs the normal load or bubble with no extra delay.
- Counters update on the same edge as the data-path action they record.

## Test plan
- Reset: after one edge with reset=1, PC_out=0x3000 and valid_out=0, and all counters read 0. Then load PC_in=0x3004 with valid_in=1 and BD_in=1; next cycle PC_out=0x3004, BD_out=1, valid_out=1, inst_cnt=1.
- Stall: load data_in=0xDEAD_BEEF, then hold stall=1 for 3 cycles while changing every input. Outputs stay unchanged throughout and stall_cnt=3.
- Bubble: apply bubble=1 with PC_in=0x3010, BD_in=1, exc_in=4. Next cycle valid_out=0, exc_out=0, data_out=0, PC_out=0x3010, BD_out=1, bubble_cnt=1.
- Flush against stall: apply exc_flush=1 and stall=1 together. Next cycle PC_out=0x4180, valid_out=0, bubble_cnt incremented, stall_cnt unchanged.
- Saturation and clear: with CNT_W=4, perform 20 valid loads; inst_cnt=15. Assert cnt_clr together with a valid load; the counter reads 0 next cycle.
- Reset mid-stall: during stall=1, assert reset=1 for one cycle. Outputs and counters take their reset values on that edge.
